// File: rtl/tile_pkg.sv
// Shared raster constants, tile types and fetch FSM states for the tile renderer.
package tile_pkg;

    localparam int H_ACTIVE   = 1280;
    localparam int H_TOTAL    = 1600;
    localparam int V_ACTIVE   = 480;
    localparam int V_TOTAL    = 525;
    localparam int H_PREFETCH = 1500;
    localparam int MAP_COLS   = 40;
    localparam int TILE_PX    = 16;

    typedef logic [5:0] tile_id_t;
    typedef logic [3:0] pix_nib_t;

    typedef enum logic [2:0] {
        IDLE,
        MAP_RD,
        MAP_CAP,
        GFX_RD0,
        GFX_RD1,
        GFX_CAP
    } fetch_state_t;

    // Pixels 0-7 sit in the low word and 8-15 in the high word, so px*4 indexes the pair directly.
    function automatic pix_nib_t pick_nibble(input logic [63:0] tile_row, input logic [3:0] px);
        return tile_row[{px, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/tile_fetch_fsm.sv
// Fetches one tile row (map byte, then two 4bpp graphics words) into a 64-bit shadow register.
module tile_fetch_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic        trig,
    input  logic [8:0]  line,
    input  logic [5:0]  col,
    output logic        tb_rd,
    output logic [8:0]  tb_addr,
    input  logic [31:0] tb_rdata,
    output logic        tg_rd,
    output logic [10:0] tg_addr,
    input  logic [31:0] tg_rdata,
    output logic [63:0] shadow
);
    import tile_pkg::*;

    fetch_state_t state, state_next;
    logic [10:0]  tile_index;
    logic [1:0]   byte_sel;
    logic [3:0]   gfx_row;
    tile_id_t     tile_id;
    logic [31:0]  word0;

    assign tile_index = 11'(line[8:4]) * 11'(MAP_COLS) + 11'(col);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            byte_sel <= '0;
            gfx_row  <= '0;
            tile_id  <= '0;
            word0    <= '0;
            shadow   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (trig) begin
                        byte_sel <= tile_index[1:0];
                        gfx_row  <= line[3:0];
                    end
                end
                MAP_RD:  tile_id <= tile_id_t'(tb_rdata[{byte_sel, 3'b000} +: 6]);
                GFX_RD0: word0   <= tg_rdata;
                // Both halves land together so the display never sees a half-updated tile row.
                GFX_RD1: shadow  <= {tg_rdata, word0};
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        tb_rd      = 1'b0;
        tb_addr    = '0;
        tg_rd      = 1'b0;
        tg_addr    = '0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (trig) begin
                        state_next = MAP_RD;
                        tb_rd      = 1'b1;
                        tb_addr    = tile_index[10:2];
                    end
                end
                MAP_RD:  state_next = MAP_CAP;
                MAP_CAP: begin
                    state_next = GFX_RD0;
                    tg_rd      = 1'b1;
                    tg_addr    = {tile_id, gfx_row, 1'b0};
                end
                GFX_RD0: begin
                    state_next = GFX_RD1;
                    tg_rd      = 1'b1;
                    tg_addr    = {tile_id, gfx_row, 1'b1};
                end
                GFX_RD1: state_next = GFX_CAP;
                GFX_CAP: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tile_renderer.sv
// Raster-driven tile renderer: one-tile-ahead prefetch, palette lookup, 2-clock RGB/sync pipeline.
module tile_renderer (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        blank_n_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic        tb_rd,
    output logic [8:0]  tb_addr,
    input  logic [31:0] tb_rdata,
    output logic        tg_rd,
    output logic [10:0] tg_addr,
    input  logic [31:0] tg_rdata,
    output logic [2:0]  pal_idx,
    input  logic [23:0] pal_rgb,
    output logic [23:0] rgb_out,
    output logic        transparent_out,
    output logic        blank_n_out,
    output logic        hsync_out,
    output logic        vsync_out
);
    import tile_pkg::*;

    logic [5:0]  col;
    logic [9:0]  next_line;
    logic        pre_trig, tile_trig, trig;
    logic [8:0]  fetch_line;
    logic [5:0]  fetch_col;
    logic [63:0] shadow, cur;
    pix_nib_t    nib;
    logic        transp_p1, vld_p1, hsync_p1, vsync_p1;

    assign col = hcount[10:5];

    // Line-end prefetch loads column 0 of the next line; in-line fetches stay one column ahead.
    always_comb begin
        next_line  = (vcount == 10'(V_TOTAL - 1)) ? '0 : vcount + 10'd1;
        pre_trig   = (hcount == 11'(H_PREFETCH)) && (next_line < 10'(V_ACTIVE));
        tile_trig  = (hcount < 11'(H_ACTIVE)) && (hcount[4:0] == 5'd0)
                     && (col != 6'(MAP_COLS - 1)) && (vcount < 10'(V_ACTIVE));
        trig       = pre_trig || tile_trig;
        fetch_line = pre_trig ? next_line[8:0] : vcount[8:0];
        fetch_col  = pre_trig ? '0 : col + 6'd1;
    end

    tile_fetch_fsm u_fetch (
        .clk      (clk),
        .reset    (reset),
        .trig     (trig),
        .line     (fetch_line),
        .col      (fetch_col),
        .tb_rd    (tb_rd),
        .tb_addr  (tb_addr),
        .tb_rdata (tb_rdata),
        .tg_rd    (tg_rd),
        .tg_addr  (tg_addr),
        .tg_rdata (tg_rdata),
        .shadow   (shadow)
    );

    assign nib = pick_nibble(cur, hcount[4:1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur             <= '0;
            pal_idx         <= '0;
            transp_p1       <= 1'b0;
            vld_p1          <= 1'b0;
            hsync_p1        <= 1'b1;
            vsync_p1        <= 1'b1;
            rgb_out         <= '0;
            transparent_out <= 1'b0;
            blank_n_out     <= 1'b0;
            hsync_out       <= 1'b1;
            vsync_out       <= 1'b1;
        end else begin
            if (hcount[4:0] == 5'd31)
                cur <= shadow;
            // stage 1: nibble to palette index, controls follow
            pal_idx   <= nib[2:0];
            transp_p1 <= nib[3];
            vld_p1    <= blank_n_in;
            hsync_p1  <= hsync_in;
            vsync_p1  <= vsync_in;
            // stage 2: palette colour, forced black outside the active window
            rgb_out         <= vld_p1 ? pal_rgb : '0;
            transparent_out <= transp_p1;
            blank_n_out     <= vld_p1;
            hsync_out       <= hsync_p1;
            vsync_out       <= vsync_p1;
        end
    end

endmodule

// File: tb/tb_tile_renderer.sv
// Bench for tile_renderer: drives raster segments, models memories, checks against a raster-level reference.
module tb_tile_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        blank_n_in, hsync_in, vsync_in;
    logic        tb_rd;
    logic [8:0]  tb_addr;
    logic [31:0] tb_rdata;
    logic        tg_rd;
    logic [10:0] tg_addr;
    logic [31:0] tg_rdata;
    logic [2:0]  pal_idx;
    logic [23:0] pal_rgb;
    logic [23:0] rgb_out;
    logic        transparent_out, blank_n_out, hsync_out, vsync_out;

    always #5 clk = ~clk;

    tile_renderer dut (
        .clk             (clk),
        .reset           (reset),
        .hcount          (hcount),
        .vcount          (vcount),
        .blank_n_in      (blank_n_in),
        .hsync_in        (hsync_in),
        .vsync_in        (vsync_in),
        .tb_rd           (tb_rd),
        .tb_addr         (tb_addr),
        .tb_rdata        (tb_rdata),
        .tg_rd           (tg_rd),
        .tg_addr         (tg_addr),
        .tg_rdata        (tg_rdata),
        .pal_idx         (pal_idx),
        .pal_rgb         (pal_rgb),
        .rgb_out         (rgb_out),
        .transparent_out (transparent_out),
        .blank_n_out     (blank_n_out),
        .hsync_out       (hsync_out),
        .vsync_out       (vsync_out)
    );

    logic [31:0] tb_mem [0:511];
    logic [31:0] tg_mem [0:2047];
    logic [23:0] pal    [0:7];

    always @(posedge clk) begin
        tb_rdata <= tb_rd ? tb_mem[tb_addr] : 32'hDEAD_BEEF;
        tg_rdata <= tg_rd ? tg_mem[tg_addr] : 32'hDEAD_BEEF;
    end
    assign pal_rgb = pal[pal_idx];

    typedef struct packed {
        logic        valid;
        logic        rst;
        logic        known;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        tr;
        logic [2:0]  idx;
        logic [23:0] rgb;
    } rec_t;

    rec_t h1, h2;
    int   checks = 0;
    int   errors = 0;
    int   ph = 0;
    int   f_id = 0;
    int   f_row = 0;
    int   cv, ch;
    logic        last_tb_rd, last_tg_rd;
    logic [8:0]  last_tb_addr;
    logic [10:0] last_tg_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (v=%0d h=%0d)", tag, obs, exp_v, cv, ch);
        end
    endtask

    // Pixel colour straight from the memory contents and the tile-map addressing rules.
    function automatic void pix_model(input int h, input int v, output logic [23:0] rgb,
                                      output logic tr, output logic [2:0] idx);
        int x, col, px, tile, id, nib;
        logic [31:0] gw;
        x    = h / 2;
        col  = x / 16;
        px   = x % 16;
        tile = (v / 16) * 40 + col;
        id   = int'((tb_mem[tile / 4] >> (8 * (tile % 4))) & 32'd63);
        gw   = tg_mem[id * 32 + (v % 16) * 2 + px / 8];
        nib  = int'((gw >> (4 * (px % 8))) & 32'd15);
        idx  = 3'(nib % 8);
        tr   = (nib >= 8);
        rgb  = pal[idx];
    endfunction

    task automatic cycle(input int h, input int v, input bit r, input bit pix);
        rec_t cr;
        bit   trig, e_tb, e_tg;
        int   line, col, idx, e_tba, e_tga;
        reset      = r;
        hcount     = 11'(h);
        vcount     = 10'(v);
        blank_n_in = (h < 1280) && (v < 480);
        hsync_in   = !(h >= 1328 && h < 1520);
        vsync_in   = !(v == 490 || v == 491);
        #1;
        e_tb = 0; e_tg = 0; e_tba = 0; e_tga = 0; trig = 0; line = 0; col = 0;
        if (r) begin
            ph = 0;
        end else if (ph == 0) begin
            if (h == 1500) begin
                line = (v == 524) ? 0 : v + 1;
                col  = 0;
                trig = (line < 480);
            end else if (h < 1280 && h % 32 == 0) begin
                line = v;
                col  = h / 32 + 1;
                trig = (col < 40) && (v < 480);
            end
            if (trig) begin
                idx   = (line / 16) * 40 + col;
                e_tb  = 1;
                e_tba = idx / 4;
                f_id  = int'((tb_mem[idx / 4] >> (8 * (idx % 4))) & 32'd63);
                f_row = line % 16;
                ph    = 1;
            end
        end else begin
            if (ph == 2) begin e_tg = 1; e_tga = f_id * 32 + f_row * 2; end
            if (ph == 3) begin e_tg = 1; e_tga = f_id * 32 + f_row * 2 + 1; end
            ph = (ph == 5) ? 0 : ph + 1;
        end
        last_tb_rd = tb_rd; last_tb_addr = tb_addr;
        last_tg_rd = tg_rd; last_tg_addr = tg_addr;
        chk("tb_rd", 32'(tb_rd), 32'(e_tb));
        if (e_tb || r) chk("tb_addr", 32'(tb_addr), 32'(e_tba));
        chk("tg_rd", 32'(tg_rd), 32'(e_tg));
        if (e_tg || r) chk("tg_addr", 32'(tg_addr), 32'(e_tga));

        if (h1.valid && (h1.rst || (h2.valid && h2.rst))) begin
            chk("rst_rgb", 32'(rgb_out), 32'd0);
            chk("rst_transp", 32'(transparent_out), 32'd0);
            chk("rst_blank", 32'(blank_n_out), 32'd0);
            chk("rst_hsync", 32'(hsync_out), 32'd1);
            chk("rst_vsync", 32'(vsync_out), 32'd1);
        end else if (h1.valid && h2.valid) begin
            chk("blank_dly", 32'(blank_n_out), 32'(h2.blank));
            chk("hsync_dly", 32'(hsync_out), 32'(h2.hs));
            chk("vsync_dly", 32'(vsync_out), 32'(h2.vs));
            if (!h2.blank) chk("rgb_blank", 32'(rgb_out), 32'd0);
            else if (h2.known) chk("rgb_pix", 32'(rgb_out), 32'(h2.rgb));
            if (h2.known) chk("transp", 32'(transparent_out), 32'(h2.tr));
        end
        if (h1.valid && h1.rst) chk("rst_pal_idx", 32'(pal_idx), 32'd0);
        else if (h1.valid && h1.known) chk("pal_idx", 32'(pal_idx), 32'(h1.idx));

        cr       = '0;
        cr.valid = 1'b1;
        cr.rst   = r;
        cr.blank = blank_n_in;
        cr.hs    = hsync_in;
        cr.vs    = vsync_in;
        cr.known = pix && blank_n_in;
        if (cr.known) pix_model(h, v, cr.rgb, cr.tr, cr.idx);
        h2 = h1;
        h1 = cr;
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int n, input bit r, input bit pix);
        for (int i = 0; i < n; i++) begin
            cycle(ch, cv, r, pix);
            ch++;
            if (ch == 1600) begin
                ch = 0;
                cv = (cv == 524) ? 0 : cv + 1;
            end
        end
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 512; i++) tb_mem[i] = $urandom;
        for (int i = 0; i < 2048; i++) tg_mem[i] = $urandom;
        for (int i = 0; i < 8; i++) pal[i] = 24'($urandom);
    endtask

    initial begin
        int lines [4];
        h1 = '0;
        h2 = '0;
        randomize_mem();

        // Reset for three cycles while the raster keeps running.
        cv = 100; ch = 1400;
        adv(3, 1, 0);
        chk("reset_rgb", 32'(rgb_out), 32'd0);
        chk("reset_blank", 32'(blank_n_out), 32'd0);
        chk("reset_hsync", 32'(hsync_out), 32'd1);
        chk("reset_vsync", 32'(vsync_out), 32'd1);
        chk("reset_pal_idx", 32'(pal_idx), 32'd0);
        chk("reset_tb_rd", 32'(last_tb_rd), 32'd0);
        adv(97, 0, 0);
        adv(1, 0, 0);
        chk("prefetch_l101_rd", 32'(last_tb_rd), 32'd1);
        chk("prefetch_l101_addr", 32'(last_tb_addr), 32'd60);
        adv(99, 0, 0);
        adv(1600, 0, 1);

        // Frame wrap: line 0 prefetched on line 524, tile 5 with a ramp of nibbles.
        tb_mem[0][7:0] = 8'h05;
        tg_mem[11'h0A0] = 32'h7654_3210;
        for (int i = 0; i < 8; i++) pal[i] = 24'(i * 32'h111111);
        cv = 524; ch = 1490;
        adv(10, 0, 0);
        adv(1, 0, 0);
        chk("wrap_tb_rd", 32'(last_tb_rd), 32'd1);
        chk("wrap_tb_addr", 32'(last_tb_addr), 32'd0);
        adv(2, 0, 0);
        chk("wrap_tg_addr0", 32'(last_tg_addr), 32'h0A0);
        adv(1, 0, 0);
        chk("wrap_tg_addr1", 32'(last_tg_addr), 32'h0A1);
        adv(96, 0, 0);
        adv(2, 0, 1);
        chk("line0_rgb_c2", 32'(rgb_out), 32'h000000);
        adv(2, 0, 1);
        chk("line0_rgb_c4", 32'(rgb_out), 32'h111111);
        adv(12, 0, 1);
        chk("line0_rgb_c16", 32'(rgb_out), 32'h777777);
        adv(1584, 0, 1);

        // Next line beyond the active area: no prefetch.
        cv = 479; ch = 1490;
        adv(11, 0, 0);
        chk("no_prefetch_479", 32'(last_tb_rd), 32'd0);
        adv(99, 0, 0);

        // Line 37 prefetch from word 20, tile 3 with a transparent nibble at px 0.
        for (int i = 0; i < 8; i++) pal[i] = 24'($urandom);
        tb_mem[20][7:0] = 8'hC3;
        tg_mem[11'h06A][3:0] = 4'h9;
        cv = 36; ch = 1490;
        adv(11, 0, 0);
        chk("l37_tb_rd", 32'(last_tb_rd), 32'd1);
        chk("l37_tb_addr", 32'(last_tb_addr), 32'd20);
        adv(2, 0, 0);
        chk("l37_tg_addr0", 32'(last_tg_addr), 32'h06A);
        adv(1, 0, 0);
        chk("l37_tg_addr1", 32'(last_tg_addr), 32'h06B);
        adv(96, 0, 0);
        adv(1, 0, 1);
        chk("transp_pal_idx", 32'(pal_idx), 32'd1);
        adv(1, 0, 1);
        chk("transp_flag", 32'(transparent_out), 32'd1);
        chk("transp_rgb", 32'(rgb_out), 32'(pal[1]));
        adv(1598, 0, 1);

        // Reset in the middle of the column-1 fetch, then a clean line afterwards.
        cv = 199; ch = 1490;
        adv(110, 0, 0);
        adv(2, 0, 1);
        adv(1, 1, 0);
        chk("midfetch_tg_rd_rst", 32'(last_tg_rd), 32'd0);
        adv(1, 0, 0);
        chk("midfetch_tg_rd_next", 32'(last_tg_rd), 32'd0);
        adv(1596, 0, 0);
        adv(1600, 0, 1);

        // Randomised memories on a few lines, including the last active line.
        lines[0] = 479;
        for (int i = 1; i < 4; i++) lines[i] = int'($urandom_range(1, 478));
        for (int i = 0; i < 4; i++) begin
            randomize_mem();
            cv = lines[i] - 1; ch = 1490;
            adv(110, 0, 0);
            adv(1600, 0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
